// File: rtl/serial_add_arb_pkg.sv
// Shared types and constants for the serial two-requester adder.
package serial_add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 2;

endpackage

// File: rtl/serial_add_arb_add2_slice.sv
// Two-bit ripple slice: s = a + b + cin, with the carry out of bit 1.
module add2_slice
  import serial_add_arb_pkg::*;
(
  input  logic               cin,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    s    = full[SLICE_W-1:0];
    cout = full[SLICE_W];
  end

endmodule

// File: rtl/serial_add_arb.sv
// Round-robin arbiter in front of a single 2-bit adder slice that is iterated
// LSB-first over WIDTH/2 cycles; the result is held until the consumer takes it.
module serial_add_arb
  import serial_add_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q;
  logic             id_q;
  logic             last_grant_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic             rsp_id_q;

  logic               grant1;
  logic               accept0, accept1;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  // Requester 1 wins only when it is alone or requester 0 was served last.
  // Ready is masked by rst_n so it drops the instant reset asserts.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant1;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
    accept0    = req0_valid && req0_ready;
    accept1    = req1_valid && req1_ready;
  end

  add2_slice u_slice (
    .cin  (carry_q),
    .a    (a_q[SLICE_W*idx_q +: SLICE_W]),
    .b    (b_q[SLICE_W*idx_q +: SLICE_W]),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    sum_d = sum_q;
    sum_d[SLICE_W*idx_q +: SLICE_W] = slice_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept0 || accept1) begin
            a_q          <= accept1 ? req1_a : req0_a;
            b_q          <= accept1 ? req1_b : req0_b;
            carry_q      <= accept1 ? req1_cin : req0_cin;
            id_q         <= accept1;
            last_grant_q <= accept1;
            idx_q        <= '0;
            state_q      <= ADD;
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_sum_q   <= sum_d;
            rsp_cout_q  <= slice_cout;
            rsp_id_q    <= id_q;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/serial_add_arb.md
SERIAL_ADD_ARB -- requirements
Module: serial_add_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; it SHALL be an even number of at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 offers an operation.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a, input, WIDTH and req0_b, input, WIDTH: requester 0 operands.
REQ-007 The block SHALL have port req0_cin, input, 1 bit: requester 0 carry-in.
REQ-008 The block SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_cin, identical in direction, width and meaning to the requester 0 ports, for requester 1.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: result available.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have ports rsp_sum, output, WIDTH: the sum; rsp_cout, output, 1 bit: the final carry-out; and rsp_id, output, 1 bit: the requester that owns the result.

Function
REQ-012 The block SHALL add a+b+cin using one 2-bit add slice, iterated over WIDTH/2 cycles, least-significant slice first.
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-014 In IDLE, the grant SHALL be computed combinationally from the valid inputs and last_grant.
- Only one requester valid: that requester is granted.
- Both valid: the requester other than last_grant is granted.
REQ-015 reqN_ready SHALL be high only in IDLE, only for the granted requester, and only while that requester's valid is high; at most one ready SHALL be high per cycle.
REQ-016 On an accept (valid and ready both high), the block SHALL:
- capture a, b, cin and id into registers;
- set last_grant to id and clear the slice index;
- go to ADD.
REQ-017 In ADD, each cycle SHALL:
- add a[2i+1:2i], b[2i+1:2i] and the carry register;
- write the 2-bit sum into sum[2i+1:2i] and the slice carry-out into the carry register;
- increment i.
After slice WIDTH/2-1 the FSM SHALL go to DONE.
REQ-018 Latency SHALL be exactly WIDTH/2 ADD cycles: rsp_valid rises on the cycle that follows the last ADD cycle.
REQ-019 In DONE, rsp_valid SHALL be 1, and rsp_sum, rsp_cout and rsp_id SHALL be held stable until rsp_ready is sampled high; on that cycle the FSM SHALL go to IDLE.
REQ-020 A new accept SHALL NOT occur in the same cycle as a response handshake; the earliest new accept is the cycle after it.
REQ-021 Overflow SHALL wrap: rsp_sum is the low WIDTH bits, and rsp_cout is bit WIDTH of the full sum.
REQ-022 reqN_valid SHALL be ignored outside IDLE, and operand changes after an accept SHALL NOT affect the result in progress.
REQ-023 rsp_ready SHALL be ignored outside DONE.

Reset
REQ-024 On rst_n low the block SHALL immediately (asynchronously) set:
- state to IDLE and the slice index to 0;
- last_grant to 1, so requester 0 wins the first contention;
- all outputs to 0: rsp_valid, rsp_sum, rsp_cout, rsp_id, req0_ready, req1_ready.
REQ-025 A reset asserted during ADD or DONE SHALL abandon the operation, and no response SHALL be produced for it after reset is released.
REQ-026 Operation SHALL resume on the first rising clk edge after rst_n goes high.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state typedef (IDLE, ADD, DONE);
- the constant SLICE_W = 2.
REQ-028 The 2-bit carry slice SHALL be a separate sub-module, add2_slice, with inputs cin, a[1:0], b[1:0] and outputs s[1:0], cout, instantiated once.
REQ-029 Operand, sum and carry registers SHALL be indexed by the slice counter; there SHALL be no per-slice instance replication.

Verification (WIDTH=8)
REQ-030 req0 a=0x3C, b=0x55, cin=0 -> rsp_sum=0x91, rsp_cout=0, rsp_id=0, with rsp_valid exactly 4 cycles after the accept edge.
REQ-031 req1 a=0xFF, b=0x01, cin=0 -> rsp_sum=0x00, rsp_cout=1, rsp_id=1; a=0xFF, b=0xFF, cin=1 -> 0xFF, cout=1.
REQ-032 Both valid from reset with ops 0x01+0x02 and 0x10+0x20 -> req0 served first (0x03, id 0), then req1 (0x30, id 1); a second contention -> req0 served first again after req1.
REQ-033 rsp_ready held low for 3 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stay stable and both reqN_ready stay 0; after rsp_ready goes high -> IDLE, and an accept occurs on the next cycle.
REQ-034 rst_n pulsed low in the 2nd ADD cycle -> outputs 0 at once; after release, no rsp_valid appears, and a fresh 0x07+0x09 request returns 0x10.
